int_ctrl_n: RTL

Parametrised interrupt controller, successor to the two-source interrupt block. Serves NUM_SRC sources with per-source mask, edge/level mode, fixed priority (index 0 highest) and an ack/RETI handshake with the instruction decoder. Sits between peripherals (button, timers, UART) and ID/PC. ID takes the vector, pushes the PC, acks, and later signals RETI.

---
 rtl/int_ctrl_pkg.sv | 19 +
 rtl/int_ctrl_n_prio_enc.sv | 23 ++
 rtl/int_ctrl_n.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the parametrised interrupt controller.
package int_ctrl_pkg;

    localparam int unsigned MAX_SRC = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    // Full-width vector; the caller truncates to its vector width.
    function automatic logic [31:0] vec_of(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] idx);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/int_ctrl_n_prio_enc.sv
// Combinational priority encoder: the lowest set request index wins.
module int_prio_enc #(
    parameter int unsigned W     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [W-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan downwards so the last hit, the lowest index, is kept.
        for (int unsigned i = W; i > 0; i--) begin
            if (req[i-1]) begin
                valid = 1'b1;
                idx   = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/int_ctrl_n.sv
// Interrupt controller top: pending/mask/enable bookkeeping plus the
// IDLE/REQ/SVC handshake towards the instruction decoder.
module int_ctrl_n
    import int_ctrl_pkg::*;
#(
    parameter int unsigned           NUM_SRC      = 2,
    parameter int unsigned           VEC_W        = 8,
    parameter logic [VEC_W-1:0]      VEC_BASE     = 8'h02,
    parameter int unsigned           VEC_STRIDE   = 2,
    parameter logic [NUM_SRC-1:0]    EDGE_MODE    = '1,
    parameter logic [NUM_SRC-1:0]    LATCH_MASKED = NUM_SRC'(1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               int_enable,
    input  logic               int_disable,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_in,
    input  logic               irq_ack,
    input  logic               reti,
    output logic               irq,
    output logic [VEC_W-1:0]   int_vector,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] in_service_o,
    output logic               global_en_o
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_t             state;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] in_svc_q;
    logic               glob_en_q;
    logic               irq_q;
    logic [VEC_W-1:0]   vec_q;
    logic [IDX_W-1:0]   cur_idx;

    logic               ack_take;
    logic [NUM_SRC-1:0] cur_onehot;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] level_set;
    logic [NUM_SRC-1:0] pend_set;
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] arb_req;
    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [VEC_W-1:0]   vec_sel;

    assign ack_take   = (state == REQ) && irq_ack;
    assign cur_onehot = NUM_SRC'(1) << cur_idx;
    assign arb_req    = pend_q & mask_q;
    assign vec_sel    = VEC_W'(vec_of(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(arb_idx)));

    always_comb begin
        edge_set  = src_in & ~prev_q & ((mask_q & {NUM_SRC{glob_en_q}}) | LATCH_MASKED);
        level_set = src_in & mask_q;
        pend_set  = (edge_set & EDGE_MODE) | (level_set & ~EDGE_MODE);
        pend_clr  = ack_take ? cur_onehot : '0;
    end

    int_prio_enc #(
        .W     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (arb_req),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    // Set is OR'ed after clear so a simultaneous re-trigger survives the ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '1;
            pend_q <= '0;
            prev_q <= '0;
        end else begin
            prev_q <= src_in;
            pend_q <= (pend_q & ~pend_clr) | pend_set;
            if (mask_wr) begin
                mask_q <= mask_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glob_en_q <= 1'b0;
        end else if (ack_take) begin
            glob_en_q <= 1'b0;
        end else if (reti || int_enable) begin
            glob_en_q <= 1'b1;
        end else if (int_disable) begin
            glob_en_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            irq_q    <= 1'b0;
            vec_q    <= '0;
            in_svc_q <= '0;
            cur_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (glob_en_q && arb_valid) begin
                        irq_q   <= 1'b1;
                        vec_q   <= vec_sel;
                        cur_idx <= arb_idx;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        irq_q    <= 1'b0;
                        vec_q    <= '0;
                        in_svc_q <= cur_onehot;
                        state    <= SVC;
                    end else if (int_disable && !int_enable) begin
                        irq_q <= 1'b0;
                        vec_q <= '0;
                        state <= IDLE;
                    end
                end
                SVC: begin
                    if (reti) begin
                        in_svc_q <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign irq          = irq_q;
    assign int_vector   = vec_q;
    assign pending_o    = pend_q;
    assign in_service_o = in_svc_q;
    assign global_en_o  = glob_en_q;

endmodule
